load_store_unit: RTL

- Memory stage directly downstream of the execute-stage ALU.
- Takes the ALU result as the effective address and register operand 2 as store data.
- Generates word-aligned data-memory transactions with byte enables over a req/ack handshake. Returns formatted load data and a completion/fault response to writeback.
- Stalls the pipeline while a transaction is outstanding.

---
 rtl/load_store_unit.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage behind the execute-stage ALU.
// Turns loads/stores into word-aligned dmem req/ack transactions with byte
// enables, formats load data and reports completion, misalign or fault.
// Optional build macro LSU_TIMEOUT_EN: abandons an access that waits
// TIMEOUT_CYCLES ACCESS cycles without dmem_ack and reports a fault.
//
// state  | meaning
// IDLE   | ready for a new request
// ACCESS | dmem_req held, waiting for dmem_ack
// RESP   | one-cycle completion pulse to writeback
module load_store_unit
`ifdef LSU_TIMEOUT_EN
  #(parameter int TIMEOUT_CYCLES = 15)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        fault,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q;
  logic        load_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        resp_valid_q, misalign_q, fault_q;
  logic [31:0] rdata_q;
  logic        dmem_req_q, dmem_we_q;
  logic [31:0] dmem_addr_q, dmem_wdata_q;
  logic [3:0]  dmem_be_q;

`ifdef LSU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
`endif

  logic        op_d, is_store_d, illegal_d, misalign_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, load_data_d, shifted_d;

  // Request classification and store lane steering from the live inputs
  always_comb begin
    op_d       = mem_read | mem_write;
    is_store_d = mem_write;
    if (is_store_d)
      illegal_d = funct3[2] | (funct3[1:0] == 2'b11);
    else
      illegal_d = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
    misalign_d = ((funct3[1:0] == 2'b01) & addr[0]) |
                 ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    be_d    = 4'b1111;
    wdata_d = 32'h0;
    if (is_store_d) begin
      case (funct3[1:0])
        2'b00:   begin be_d = 4'b0001 << addr[1:0]; wdata_d = {4{wdata[7:0]}}; end
        2'b01:   begin be_d = 4'b0011 << addr[1:0]; wdata_d = {2{wdata[15:0]}}; end
        default: begin be_d = 4'b1111;              wdata_d = wdata; end
      endcase
    end
  end

  // Load data extraction at the captured byte offset
  always_comb begin
    shifted_d = dmem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_data_d = {{24{shifted_d[7]}}, shifted_d[7:0]};
      3'b001:  load_data_d = {{16{shifted_d[15]}}, shifted_d[15:0]};
      3'b100:  load_data_d = {24'h0, shifted_d[7:0]};
      3'b101:  load_data_d = {16'h0, shifted_d[15:0]};
      default: load_data_d = dmem_rdata;
    endcase
  end

  // Sequencer with registered memory-side and response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      load_q       <= 1'b0;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      resp_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      fault_q      <= 1'b0;
      rdata_q      <= 32'h0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= 32'h0;
      dmem_be_q    <= 4'b0000;
      dmem_wdata_q <= 32'h0;
`ifdef LSU_TIMEOUT_EN
      tmo_q        <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && op_d) begin
            f3_q   <= funct3;
            off_q  <= addr[1:0];
            load_q <= ~is_store_d;
            if (illegal_d) begin
              fault_q      <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else if (misalign_d) begin
              misalign_q   <= 1'b1;
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= is_store_d;
              dmem_addr_q  <= {addr[31:2], 2'b00};
              dmem_be_q    <= be_d;
              dmem_wdata_q <= wdata_d;
`ifdef LSU_TIMEOUT_EN
              tmo_q        <= TW'(TIMEOUT_CYCLES - 1);
`endif
              state_q      <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'h0;
            dmem_be_q    <= 4'b0000;
            dmem_wdata_q <= 32'h0;
            rdata_q      <= load_q ? load_data_d : 32'h0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmo_q == '0) begin
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'h0;
            dmem_be_q    <= 4'b0000;
            dmem_wdata_q <= 32'h0;
            rdata_q      <= 32'h0;
            fault_q      <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            tmo_q <= tmo_q - TW'(1);
          end
`endif
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          misalign_q   <= 1'b0;
          fault_q      <= 1'b0;
          rdata_q      <= 32'h0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign stall      = ((state_q == IDLE) & req_valid & op_d) | (state_q == ACCESS);
  assign resp_valid = resp_valid_q;
  assign rdata      = rdata_q;
  assign misalign   = misalign_q;
  assign fault      = fault_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_be    = dmem_be_q;
  assign dmem_wdata = dmem_wdata_q;

endmodule
